// File: rtl/uart_frame_decoder.sv
// Byte-stream frame decoder: SYNC, CMD, LEN, LEN payload bytes, XOR checksum.
// A verified frame is held on frame_valid until the consumer handshakes.
module uart_frame_decoder #(
  parameter int unsigned          DATA_BITS      = 8,
  parameter int unsigned          MAX_PAYLOAD    = 16,
  parameter logic [DATA_BITS-1:0] SYNC_BYTE      = 8'hA5,
  parameter int unsigned          TIMEOUT_CYCLES = 100000
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             byte_valid,
  input  logic [DATA_BITS-1:0]             byte_data,
  output logic                             frame_valid,
  input  logic                             frame_ready,
  output logic [DATA_BITS-1:0]             frame_cmd,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] frame_len,
  input  logic [$clog2(MAX_PAYLOAD)-1:0]   rd_addr,
  output logic [DATA_BITS-1:0]             rd_data,
  output logic                             err_chk,
  output logic                             err_len,
  output logic                             err_timeout,
  output logic                             err_overrun
);

  localparam int unsigned LenW  = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned AddrW = $clog2(MAX_PAYLOAD);
  localparam int unsigned CntW  = $clog2(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {StHunt, StCmd, StLen, StPayload, StCheck, StHold} state_e;

  state_e                 state_q, state_d;
  logic [DATA_BITS-1:0]   cmd_q, cmd_d;
  logic [LenW-1:0]        len_q, len_d;
  logic [AddrW-1:0]       idx_q, idx_d;
  logic [DATA_BITS-1:0]   xor_q, xor_d;
  logic [CntW-1:0]        cnt_q, cnt_d;
  logic                   err_chk_q, err_chk_d;
  logic                   err_len_q, err_len_d;
  logic                   err_tmo_q, err_tmo_d;
  logic                   err_ovr_q, err_ovr_d;
  logic                   mem_we;
  logic [DATA_BITS-1:0]   mem_q [MAX_PAYLOAD];

  always_comb begin
    state_d   = state_q;
    cmd_d     = cmd_q;
    len_d     = len_q;
    idx_d     = idx_q;
    xor_d     = xor_q;
    cnt_d     = cnt_q;
    err_chk_d = 1'b0;
    err_len_d = 1'b0;
    err_tmo_d = 1'b0;
    err_ovr_d = 1'b0;
    mem_we    = 1'b0;

    // Inter-byte watchdog only runs while a frame is being collected.
    if (state_q inside {StCmd, StLen, StPayload, StCheck}) begin
      if (byte_valid) begin
        cnt_d = '0;
      end else if (cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
        err_tmo_d = 1'b1;
        state_d   = StHunt;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end

    unique case (state_q)
      StHunt: begin
        if (byte_valid && byte_data == SYNC_BYTE) begin
          state_d = StCmd;
          cnt_d   = '0;
        end
      end
      StCmd: begin
        if (byte_valid) begin
          cmd_d   = byte_data;
          xor_d   = byte_data;
          state_d = StLen;
        end
      end
      StLen: begin
        if (byte_valid) begin
          len_d = LenW'(byte_data);
          xor_d = xor_q ^ byte_data;
          idx_d = '0;
          if (32'(byte_data) > MAX_PAYLOAD) begin
            err_len_d = 1'b1;
            state_d   = StHunt;
          end else if (byte_data == '0) begin
            state_d = StCheck;
          end else begin
            state_d = StPayload;
          end
        end
      end
      StPayload: begin
        if (byte_valid) begin
          mem_we = 1'b1;
          xor_d  = xor_q ^ byte_data;
          idx_d  = idx_q + AddrW'(1);
          if (LenW'(idx_q) == len_q - LenW'(1)) state_d = StCheck;
        end
      end
      StCheck: begin
        if (byte_valid) begin
          if (byte_data == xor_q) begin
            state_d = StHold;
          end else begin
            err_chk_d = 1'b1;
            state_d   = StHunt;
          end
        end
      end
      StHold: begin
        // Bytes cannot be buffered while a frame is held, including on the handshake cycle.
        if (byte_valid)  err_ovr_d = 1'b1;
        if (frame_ready) state_d   = StHunt;
      end
      default: state_d = StHunt;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StHunt;
      cmd_q     <= '0;
      len_q     <= '0;
      idx_q     <= '0;
      xor_q     <= '0;
      cnt_q     <= '0;
      err_chk_q <= 1'b0;
      err_len_q <= 1'b0;
      err_tmo_q <= 1'b0;
      err_ovr_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cmd_q     <= cmd_d;
      len_q     <= len_d;
      idx_q     <= idx_d;
      xor_q     <= xor_d;
      cnt_q     <= cnt_d;
      err_chk_q <= err_chk_d;
      err_len_q <= err_len_d;
      err_tmo_q <= err_tmo_d;
      err_ovr_q <= err_ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (mem_we) mem_q[idx_q] <= byte_data;
  end

  assign frame_valid = (state_q == StHold);
  assign frame_cmd   = cmd_q;
  assign frame_len   = len_q;
  assign rd_data     = mem_q[rd_addr];
  assign err_chk     = err_chk_q;
  assign err_len     = err_len_q;
  assign err_timeout = err_tmo_q;
  assign err_overrun = err_ovr_q;

endmodule

// File: tb/tb_uart_frame_decoder.sv
`timescale 1ns/100ps
// Bench for uart_frame_decoder: directed and random frames; expected frame and error
// events are queued by the stimulus and matched by an independent monitor.
module tb_uart_frame_decoder;

  localparam int         T    = 40;
  localparam int         MaxP = 16;
  localparam logic [7:0] Sync = 8'hA5;

  typedef enum int {EvFrame, EvChk, EvLen, EvTmo, EvOvr} ev_kind_e;
  typedef struct packed {
    ev_kind_e           kind;
    int                 due;
    int                 tol;
    logic [7:0]         cmd;
    int                 len;
    logic [8*MaxP-1:0]  pl;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       byte_valid = 1'b0;
  logic [7:0] byte_data = 8'h00;
  logic       frame_ready = 1'b0;
  logic [3:0] rd_addr = 4'h0;
  logic       frame_valid;
  logic [7:0] frame_cmd;
  logic [4:0] frame_len;
  logic [7:0] rd_data;
  logic       err_chk, err_len, err_timeout, err_overrun;

  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  bit   mon_en = 1'b0;
  bit   rand_ready = 1'b0;
  ev_t  exp_q[$];
  logic [7:0] seq[$];

  uart_frame_decoder #(
    .DATA_BITS(8), .MAX_PAYLOAD(MaxP), .SYNC_BYTE(Sync), .TIMEOUT_CYCLES(T)
  ) dut (
    .clk(clk), .rst(rst), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_valid(frame_valid), .frame_ready(frame_ready), .frame_cmd(frame_cmd),
    .frame_len(frame_len), .rd_addr(rd_addr), .rd_data(rd_data), .err_chk(err_chk),
    .err_len(err_len), .err_timeout(err_timeout), .err_overrun(err_overrun)
  );

  always #10 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h, required %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] b);
    byte_valid = 1'b1;
    byte_data  = b;
    tick();
    byte_valid = 1'b0;
  endtask

  // Sends seq; the expected event is queued just before the byte that triggers it.
  task automatic send_seq(input bit has_ev, input ev_t e, input int gap_max);
    for (int i = 0; i < seq.size(); i++) begin
      if (has_ev && i == seq.size() - 1) begin
        e.due = cyc + 1;
        exp_q.push_back(e);
      end
      send_byte(seq[i]);
      if (i != seq.size() - 1) idle($urandom_range(0, gap_max));
    end
    seq.delete();
  endtask

  task automatic build_frame(input logic [7:0] cmd, input int len, input bit bad_chk,
                             output ev_t e);
    logic [7:0] x;
    logic [7:0] b;
    e      = '0;
    e.kind = bad_chk ? EvChk : EvFrame;
    e.cmd  = cmd;
    e.len  = len;
    x      = cmd ^ 8'(len);
    seq.push_back(Sync);
    seq.push_back(cmd);
    seq.push_back(8'(len));
    for (int i = 0; i < len; i++) begin
      b = 8'($urandom);
      e.pl[i*8 +: 8] = b;
      x ^= b;
      seq.push_back(b);
    end
    seq.push_back(bad_chk ? (x ^ 8'($urandom_range(1, 255))) : x);
  endtask

  task automatic wait_clear();
    int n = 0;
    while (frame_valid === 1'b1 && n < 300) begin
      tick();
      n++;
    end
    if (frame_valid === 1'b1) check("frame_consumed_bound", 32'(frame_valid), 0);
  endtask

  task automatic check_quiet(input string name);
    check({name, "_valid"}, 32'(frame_valid), 0);
    check({name, "_cmd"}, 32'(frame_cmd), 0);
    check({name, "_len"}, 32'(frame_len), 0);
    check({name, "_errs"}, 32'({err_chk, err_len, err_timeout, err_overrun}), 0);
  endtask

  // Frame consumer: random ready when enabled, otherwise the main process drives it.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rand_ready) frame_ready = ($urandom_range(0, 2) != 0);
    end
  end

  // Monitor: matches DUT frames and error pulses against the expected-event queue.
  initial begin
    ev_t        cur;
    ev_t        e;
    ev_kind_e   kind;
    logic       fv_prev = 1'b0;
    logic       hs_prev = 1'b0;
    logic       rst_prev = 1'b1;
    int         n_err;
    int         nmis;
    int         dev;
    cur = '0;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        n_err = 0;
        if (err_chk)     n_err++;
        if (err_len)     n_err++;
        if (err_timeout) n_err++;
        if (err_overrun) n_err++;
        check("err_exclusive", 32'(n_err <= 1), 1);
        if (n_err != 0) begin
          kind = err_chk ? EvChk : err_len ? EvLen : err_timeout ? EvTmo : EvOvr;
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_err: got kind %0d, required none (cycle %0d)", kind, cyc);
          end else begin
            e = exp_q.pop_front();
            check("err_kind", kind, e.kind);
            dev = cyc - e.due;
            if (dev >= -e.tol && dev <= e.tol) dev = 0;
            check("err_time_dev", dev, 0);
          end
        end
        if (!rst && !rst_prev) begin
          if (frame_valid && !fv_prev) begin
            if (exp_q.size() == 0) begin
              total++;
              bad++;
              $display("FAIL unexpected_frame: got cmd %0h, required none", frame_cmd);
            end else begin
              cur = exp_q.pop_front();
              check("frame_kind", cur.kind, EvFrame);
              check("frame_latency", cyc, cur.due);
            end
          end
          if (frame_valid) begin
            check("frame_cmd", 32'(frame_cmd), 32'(cur.cmd));
            check("frame_len", 32'(frame_len), cur.len);
            nmis = 0;
            for (int i = 0; i < cur.len && i < MaxP; i++) begin
              rd_addr = 4'(i);
              #0.5;
              if (rd_data !== cur.pl[i*8 +: 8]) nmis++;
            end
            check("payload_mismatches", nmis, 0);
          end
          if (fv_prev && hs_prev) check("drop_after_handshake", 32'(frame_valid), 0);
          else if (fv_prev)       check("held_until_ready", 32'(frame_valid), 1);
        end
      end
      hs_prev  = frame_valid && frame_ready;
      fv_prev  = frame_valid;
      rst_prev = rst;
    end
  end

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    ev_t        e;
    logic [7:0] b;
    int         sel;
    int         len;
    int         ng;

    idle(3);
    rst = 1'b0;
    check_quiet("reset");
    mon_en = 1'b1;

    // Good frame A5 01 02 11 22 30, held with ready low well past the timeout.
    e = '0; e.kind = EvFrame; e.cmd = 8'h01; e.len = 2; e.pl[7:0] = 8'h11; e.pl[15:8] = 8'h22;
    seq.push_back(8'hA5); seq.push_back(8'h01); seq.push_back(8'h02);
    seq.push_back(8'h11); seq.push_back(8'h22); seq.push_back(8'h30);
    send_seq(1'b1, e, 2);
    idle(T + 5);
    frame_ready = 1'b1;
    tick();
    frame_ready = 1'b0;
    wait_clear();
    idle(2);

    // Zero-length frame, then a frame with a bad checksum.
    rand_ready = 1'b1;
    e = '0; e.kind = EvFrame; e.cmd = 8'h7F; e.len = 0;
    seq.push_back(8'hA5); seq.push_back(8'h7F); seq.push_back(8'h00); seq.push_back(8'h7F);
    send_seq(1'b1, e, 1);
    wait_clear();
    e = '0; e.kind = EvChk;
    seq.push_back(8'hA5); seq.push_back(8'h01); seq.push_back(8'h00); seq.push_back(8'h00);
    send_seq(1'b1, e, 1);
    idle(3);

    // Length violation followed by a good frame.
    e = '0; e.kind = EvLen;
    seq.push_back(8'hA5); seq.push_back(8'h01); seq.push_back(8'h11);
    send_seq(1'b1, e, 0);
    idle(2);
    build_frame(8'h3C, 16, 1'b0, e);
    send_seq(1'b1, e, 1);
    wait_clear();

    // Overrun while holding, then a byte on the handshake cycle itself.
    rand_ready  = 1'b0;
    frame_ready = 1'b0;
    build_frame(8'h5A, 5, 1'b0, e);
    send_seq(1'b1, e, 2);
    idle(2);
    for (int k = 0; k < 3; k++) begin
      e = '0; e.kind = EvOvr; e.due = cyc + 1;
      exp_q.push_back(e);
      send_byte((k == 1) ? Sync : 8'($urandom));
      idle(1);
    end
    frame_ready = 1'b1;
    e = '0; e.kind = EvOvr; e.due = cyc + 1;
    exp_q.push_back(e);
    send_byte(8'h42);
    frame_ready = 1'b0;
    wait_clear();
    idle(2);

    // Leading garbage, then a stalled frame that must time out once.
    seq.push_back(8'h00); seq.push_back(8'hFF); seq.push_back(8'hA5); seq.push_back(8'h01);
    send_seq(1'b0, e, 1);
    e = '0; e.kind = EvTmo; e.due = cyc + T - 1; e.tol = 2;
    exp_q.push_back(e);
    idle(T + 5);
    check("timeout_single_pulse", exp_q.size(), 0);
    rand_ready = 1'b1;
    build_frame(8'hA5, 3, 1'b0, e);
    send_seq(1'b1, e, 2);
    wait_clear();

    // Reset mid-payload, then reset while holding.
    seq.push_back(8'hA5); seq.push_back(8'h01); seq.push_back(8'h04); seq.push_back(8'h11);
    send_seq(1'b0, e, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("reset_mid_payload");
    idle(T + 5);
    build_frame(8'h99, 4, 1'b0, e);
    send_seq(1'b1, e, 1);
    wait_clear();
    rand_ready  = 1'b0;
    frame_ready = 1'b0;
    build_frame(8'h12, 7, 1'b0, e);
    send_seq(1'b1, e, 1);
    idle(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check_quiet("reset_in_hold");
    idle(2);

    // Random traffic.
    rand_ready = 1'b1;
    for (int f = 0; f < 60; f++) begin
      ng = $urandom_range(0, 2);
      for (int g = 0; g < ng; g++) begin
        do b = 8'($urandom); while (b == Sync);
        seq.push_back(b);
      end
      if (ng != 0) send_seq(1'b0, e, 2);
      sel = $urandom_range(0, 99);
      if (sel < 85) begin
        len = $urandom_range(0, MaxP);
        build_frame(8'($urandom), len, sel >= 70, e);
      end else begin
        e = '0; e.kind = EvLen;
        seq.push_back(Sync);
        seq.push_back(8'($urandom));
        seq.push_back(8'($urandom_range(MaxP + 1, 255)));
      end
      send_seq(1'b1, e, 3);
      if (e.kind == EvFrame) wait_clear();
      else idle(2);
    end

    idle(5);
    check("events_left", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_frame_decoder.md
UART_FRAME_DECODER -- requirements
Module: uart_frame_decoder

Interface
REQ-001 Parameter DATA_BITS, default 8: width of each received byte.
REQ-002 Parameter MAX_PAYLOAD, default 16: maximum payload bytes per frame.
REQ-003 Parameter SYNC_BYTE, default 8'hA5: frame start marker.
REQ-004 Parameter TIMEOUT_CYCLES, default 100000: maximum clk cycles allowed between bytes inside a frame.
REQ-005 clk  input  1  sole clock; all logic on rising edge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 byte_valid  input  1  one-cycle strobe: byte_data holds a received byte; no backpressure upstream.
REQ-008 byte_data  input  DATA_BITS  received byte.
REQ-009 frame_valid  output  1  a checked frame is available.
REQ-010 frame_ready  input  1  consumer accepts the frame.
REQ-011 frame_cmd  output  DATA_BITS  command byte of the held frame.
REQ-012 frame_len  output  $clog2(MAX_PAYLOAD+1)  payload length of the held frame.
REQ-013 rd_addr  input  $clog2(MAX_PAYLOAD)  payload read index.
REQ-014 rd_data  output  DATA_BITS  payload byte at rd_addr, combinational; undefined for rd_addr >= frame_len.
REQ-015 err_chk, err_len, err_timeout, err_overrun  output  1 each  one-cycle error pulses.

Function
REQ-016 The frame format SHALL be SYNC_BYTE, CMD, LEN, LEN payload bytes, then CHK, where CHK = XOR of CMD, LEN and all payload bytes.
REQ-017 The FSM SHALL have the states HUNT, CMD, LEN, PAYLOAD, CHECK and HOLD.
REQ-018 HUNT: a byte equal to SYNC_BYTE -> CMD; any other byte is discarded silently.
REQ-019 CMD: the byte is stored as cmd and seeds the running XOR; next state is LEN.
REQ-020 LEN: LEN > MAX_PAYLOAD -> err_len pulse, HUNT; LEN == 0 -> CHECK; otherwise -> PAYLOAD. The byte is stored and XORed in.
REQ-021 PAYLOAD: each byte is written to buffer[idx] and XORed in; idx increments; when idx reaches LEN-1 -> CHECK.
REQ-022 CHECK: byte == running XOR -> HOLD with frame_valid=1 on the following cycle; mismatch -> err_chk pulse, HUNT.
REQ-023 HOLD: frame_valid, frame_cmd, frame_len and buffer contents SHALL stay stable until frame_valid && frame_ready.
REQ-024 On handshake, frame_valid SHALL deassert on the next cycle and the state SHALL return to HUNT.
REQ-025 frame_ready while frame_valid is low SHALL be ignored.
REQ-026 A byte_valid arriving in HOLD SHALL be dropped with an err_overrun pulse; the held frame SHALL be unaffected.
REQ-027 A byte_valid coincident with the handshake cycle SHALL be dropped with err_overrun.
REQ-028 Timeout counter: cleared on every byte_valid and on entry to CMD.
REQ-029 In CMD/LEN/PAYLOAD/CHECK, reaching TIMEOUT_CYCLES-1 cycles without a byte SHALL pulse err_timeout and return the FSM to HUNT.
REQ-030 The timeout counter SHALL not run in HUNT or HOLD.
REQ-031 A SYNC_BYTE value appearing mid-frame SHALL be treated as ordinary data, not a resync.
REQ-032 Latency: frame_valid SHALL rise exactly 1 cycle after the byte_valid carrying a correct CHK.
REQ-033 Error pulses SHALL last exactly 1 cycle and be mutually exclusive per cycle.

Reset
REQ-034 rst SHALL force HUNT and clear idx, the running XOR and the timeout counter.
REQ-035 rst SHALL drive frame_valid, frame_cmd, frame_len and all error outputs to 0.
REQ-036 Buffer contents need not be cleared on rst.
REQ-037 rst mid-frame or during HOLD SHALL discard the frame without any error pulse.

Verification
REQ-038 Good frame: bytes A5 01 02 11 22 30 -> frame_valid 1 cycle after 30; cmd=01, len=2, rd_data[0]=11, rd_data[1]=22; held until frame_ready.
REQ-039 Zero-length frame: A5 7F 00 7F -> frame_valid with cmd=7F, len=0; a following bad frame A5 01 00 00 -> err_chk, no frame_valid.
REQ-040 Length violation: A5 01 11 with MAX_PAYLOAD=16 -> err_len on the cycle after 11; FSM in HUNT; a subsequent good frame is decoded correctly.
REQ-041 Overrun: hold frame with frame_ready=0, send 3 bytes -> 3 err_overrun pulses, frame unchanged; assert frame_ready -> frame_valid drops next cycle.
REQ-042 Timeout: A5 01 then idle for TIMEOUT_CYCLES -> single err_timeout pulse and HUNT; leading garbage 00 FF before A5 is ignored with no error.
REQ-043 Reset mid-PAYLOAD: rst after A5 01 04 11 -> all outputs 0, no error pulse; the next good frame is decoded normally.
